pkt_router: RTL and testbench

//  Parametrised host-packet deframer between UART byte receiver and N_DEST slave interfaces.

---
 rtl/pkt_router.sv | 215 +++++++++++++++++++++
 tb/tb_pkt_router.sv | 257 +++++++++++++++++++++++++
 2 files changed

// File: rtl/pkt_router.sv
// rtl/pkt_router.sv - host packet deframer routing payload bytes to N_DEST slave channels
// Frame: PREFIX, dev addr, dest idx, LEN, LEN payload bytes, check byte; cut-through or store-and-forward.
module pkt_router #(
   parameter int         N_DEST      = 4,
   parameter logic [7:0] DEV_ADDR    = 8'h01,
   parameter logic [7:0] PREFIX      = 8'hDD,
   parameter int         CHK_MODE    = 0,
   parameter int         BUFFERED    = 0,
   parameter int         MAX_LEN     = 64,
   parameter int         TIMEOUT_CYC = 48000
) (
   input  logic              clk,
   input  logic              n_rst,
   input  logic [7:0]        rx_data,
   input  logic              rx_valid,
   input  logic              out_ready,
   output logic [7:0]        master_data,
   output logic [N_DEST-1:0] valid_bus,
   output logic              pkt_done,
   output logic              pkt_ok,
   output logic [2:0]        err_code
);

   localparam int DW    = (N_DEST > 1) ? $clog2(N_DEST) : 1;
   localparam int DEPTH = (BUFFERED != 0) ? MAX_LEN : 1;
   localparam int AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int TW    = $clog2(TIMEOUT_CYC + 1);

   localparam logic [TW-1:0]     TO_LAST   = TW'(TIMEOUT_CYC - 1);
   localparam logic [7:0]        N_DEST_B  = 8'(N_DEST);
   localparam logic [7:0]        MAX_LEN_B = 8'(MAX_LEN);
   localparam logic [N_DEST-1:0] ONE_HOT0  = N_DEST'(1);

   localparam logic [2:0] ERR_NONE    = 3'd0;
   localparam logic [2:0] ERR_CHK     = 3'd1;
   localparam logic [2:0] ERR_DEST    = 3'd2;
   localparam logic [2:0] ERR_LEN     = 3'd3;
   localparam logic [2:0] ERR_TIMEOUT = 3'd4;
   localparam logic [2:0] ERR_OVERRUN = 3'd5;

   typedef enum logic [2:0] {
      S_IDLE, S_ADDR, S_DEST, S_LEN, S_DATA, S_SKIP, S_CHK, S_DRAIN
   } state_t;

   state_t            state_q;
   logic              addr_ok_q, dest_ok_q, len_ok_q;
   logic [DW-1:0]     dest_q;
   logic [7:0]        len_q, cnt_q, rd_ptr_q;
   logic [7:0]        acc_q, acc_d;
   logic [TW-1:0]     to_cnt_q, to_cnt_d;
   logic [7:0]        master_data_q;
   logic [N_DEST-1:0] valid_bus_q;
   logic              pkt_done_q, pkt_ok_q;
   logic [2:0]        err_code_q;
   logic [7:0]        buf_q [DEPTH];

   logic              in_frame, timeout, chk_ok, frame_ok, len_ok_d;
   logic [2:0]        chk_err;

   function automatic logic [7:0] chk_next(input logic [7:0] acc, input logic [7:0] b);
      logic [7:0] c;
      c = acc ^ b;
      if (CHK_MODE == 0) begin
         c = acc + b;
      end else if (CHK_MODE == 2) begin
         // CRC-8, polynomial x^8+x^2+x+1, MSB first
         for (int i = 0; i < 8; i++) begin
            c = c[7] ? ({c[6:0], 1'b0} ^ 8'h07) : {c[6:0], 1'b0};
         end
      end
      return c;
   endfunction

   assign in_frame = (state_q != S_IDLE) && (state_q != S_DRAIN);
   assign timeout  = in_frame && !rx_valid && (to_cnt_q == TO_LAST);
   assign chk_ok   = (rx_data == acc_q);
   assign frame_ok = addr_ok_q && dest_ok_q && len_ok_q && chk_ok;
   assign len_ok_d = (BUFFERED == 0) || (rx_data <= MAX_LEN_B);

   always_comb begin
      acc_d    = chk_next(acc_q, rx_data);
      to_cnt_d = rx_valid ? '0 : to_cnt_q + 1'b1;
      chk_err  = ERR_NONE;
      // A frame for another device is dropped silently whatever else is wrong with it
      if (addr_ok_q) begin
         if (!dest_ok_q)     chk_err = ERR_DEST;
         else if (!len_ok_q) chk_err = ERR_LEN;
         else if (!chk_ok)   chk_err = ERR_CHK;
      end
   end

   always_ff @(posedge clk) begin
      if ((BUFFERED != 0) && (state_q == S_DATA) && rx_valid) begin
         buf_q[cnt_q[AW-1:0]] <= rx_data;
      end
   end

   always_ff @(posedge clk or negedge n_rst) begin
      if (!n_rst) begin
         state_q       <= S_IDLE;
         addr_ok_q     <= 1'b0;
         dest_ok_q     <= 1'b0;
         len_ok_q      <= 1'b0;
         dest_q        <= '0;
         len_q         <= '0;
         cnt_q         <= '0;
         rd_ptr_q      <= '0;
         acc_q         <= '0;
         to_cnt_q      <= '0;
         master_data_q <= '0;
         valid_bus_q   <= '0;
         pkt_done_q    <= 1'b0;
         pkt_ok_q      <= 1'b0;
         err_code_q    <= ERR_NONE;
      end else begin
         pkt_done_q <= 1'b0;
         if (state_q != S_DRAIN) valid_bus_q <= '0;
         to_cnt_q <= in_frame ? to_cnt_d : '0;

         if (timeout) begin
            pkt_done_q <= 1'b1;
            pkt_ok_q   <= 1'b0;
            err_code_q <= ERR_TIMEOUT;
            state_q    <= S_IDLE;
         end else begin
            case (state_q)
               S_IDLE: begin
                  if (rx_valid && (rx_data == PREFIX)) begin
                     err_code_q <= ERR_NONE;
                     pkt_ok_q   <= 1'b0;
                     acc_q      <= '0;
                     state_q    <= S_ADDR;
                  end
               end
               S_ADDR: begin
                  if (rx_valid) begin
                     addr_ok_q <= (rx_data == DEV_ADDR);
                     state_q   <= S_DEST;
                  end
               end
               S_DEST: begin
                  if (rx_valid) begin
                     dest_q    <= rx_data[DW-1:0];
                     dest_ok_q <= (rx_data < N_DEST_B);
                     state_q   <= S_LEN;
                  end
               end
               S_LEN: begin
                  if (rx_valid) begin
                     len_q    <= rx_data;
                     len_ok_q <= len_ok_d;
                     cnt_q    <= '0;
                     if (rx_data == 8'd0)                           state_q <= S_CHK;
                     else if (!addr_ok_q || !dest_ok_q || !len_ok_d) state_q <= S_SKIP;
                     else                                            state_q <= S_DATA;
                  end
               end
               S_DATA: begin
                  if (rx_valid) begin
                     acc_q <= acc_d;
                     cnt_q <= cnt_q + 8'd1;
                     if (BUFFERED == 0) begin
                        master_data_q <= rx_data;
                        valid_bus_q   <= ONE_HOT0 << dest_q;
                     end
                     if (cnt_q + 8'd1 == len_q) state_q <= S_CHK;
                  end
               end
               S_SKIP: begin
                  if (rx_valid) begin
                     cnt_q <= cnt_q + 8'd1;
                     if (cnt_q + 8'd1 == len_q) state_q <= S_CHK;
                  end
               end
               S_CHK: begin
                  if (rx_valid) begin
                     pkt_done_q <= 1'b1;
                     pkt_ok_q   <= frame_ok;
                     err_code_q <= chk_err;
                     // The first buffered byte is presented together with pkt_done
                     if ((BUFFERED != 0) && frame_ok && (len_q != 8'd0)) begin
                        master_data_q <= buf_q[0];
                        valid_bus_q   <= ONE_HOT0 << dest_q;
                        rd_ptr_q      <= 8'd1;
                        state_q       <= S_DRAIN;
                     end else begin
                        state_q <= S_IDLE;
                     end
                  end
               end
               S_DRAIN: begin
                  if (rx_valid) err_code_q <= ERR_OVERRUN;
                  if (out_ready) begin
                     if (rd_ptr_q == len_q) begin
                        valid_bus_q <= '0;
                        state_q     <= S_IDLE;
                     end else begin
                        master_data_q <= buf_q[rd_ptr_q[AW-1:0]];
                        rd_ptr_q      <= rd_ptr_q + 8'd1;
                     end
                  end
               end
               default: state_q <= S_IDLE;
            endcase
         end
      end
   end

   assign master_data = master_data_q;
   assign valid_bus   = valid_bus_q;
   assign pkt_done    = pkt_done_q;
   assign pkt_ok      = pkt_ok_q;
   assign err_code    = err_code_q;

endmodule

// File: tb/tb_pkt_router.sv
// tb/tb_pkt_router.sv - directed table bench for pkt_router
// Four instances: cut-through sum, store-and-forward sum, cut-through xor, cut-through crc.
module tb_pkt_router;

   logic       clk = 1'b0;
   logic       n_rst = 1'b0;
   logic [7:0] rx_data = 8'h00;
   logic       rx_valid = 1'b0;
   logic       out_ready = 1'b1;
   int         rdy_mode = 0;

   logic [7:0] md_ct, md_sf, md_x, md_c;
   logic [3:0] vb_ct, vb_sf, vb_x, vb_c;
   logic [2:0] ec_ct, ec_sf, ec_x, ec_c;
   logic       pd_ct, pd_sf, pd_x, pd_c;
   logic       po_ct, po_sf, po_x, po_c;

   wire [3:0][7:0] md = {md_c, md_x, md_sf, md_ct};
   wire [3:0][3:0] vb = {vb_c, vb_x, vb_sf, vb_ct};
   wire [3:0][2:0] ec = {ec_c, ec_x, ec_sf, ec_ct};
   wire [3:0]      pd = {pd_c, pd_x, pd_sf, pd_ct};
   wire [3:0]      po = {po_c, po_x, po_sf, po_ct};

   always #5 clk = ~clk;

   pkt_router #(.N_DEST(4), .CHK_MODE(0), .BUFFERED(0), .MAX_LEN(8), .TIMEOUT_CYC(40)) u_ct (
      .clk(clk), .n_rst(n_rst), .rx_data(rx_data), .rx_valid(rx_valid), .out_ready(out_ready),
      .master_data(md_ct), .valid_bus(vb_ct), .pkt_done(pd_ct), .pkt_ok(po_ct), .err_code(ec_ct));
   pkt_router #(.N_DEST(4), .CHK_MODE(0), .BUFFERED(1), .MAX_LEN(8), .TIMEOUT_CYC(40)) u_sf (
      .clk(clk), .n_rst(n_rst), .rx_data(rx_data), .rx_valid(rx_valid), .out_ready(out_ready),
      .master_data(md_sf), .valid_bus(vb_sf), .pkt_done(pd_sf), .pkt_ok(po_sf), .err_code(ec_sf));
   pkt_router #(.N_DEST(4), .CHK_MODE(1), .BUFFERED(0), .MAX_LEN(8), .TIMEOUT_CYC(40)) u_x (
      .clk(clk), .n_rst(n_rst), .rx_data(rx_data), .rx_valid(rx_valid), .out_ready(out_ready),
      .master_data(md_x), .valid_bus(vb_x), .pkt_done(pd_x), .pkt_ok(po_x), .err_code(ec_x));
   pkt_router #(.N_DEST(4), .CHK_MODE(2), .BUFFERED(0), .MAX_LEN(8), .TIMEOUT_CYC(40)) u_c (
      .clk(clk), .n_rst(n_rst), .rx_data(rx_data), .rx_valid(rx_valid), .out_ready(out_ready),
      .master_data(md_c), .valid_bus(vb_c), .pkt_done(pd_c), .pkt_ok(po_c), .err_code(ec_c));

   typedef struct packed {
      int             nb;
      logic [127:0]   fr;
      logic [3:0]     bus;
      logic [3:0]     dlv;
      logic [3:0]     care;
      logic [3:0]     okv;
      logic [3:0][2:0] errv;
   } vec_t;

   vec_t vecs [11];
   int   checks = 0;
   int   failures = 0;

   int         n_str [4];
   int         n_done [4];
   logic [3:0] ok_s;
   logic [3:0] bus_or [4];
   logic [7:0] dat [4][16];
   int         viol = 0;

   initial forever begin
      @(posedge clk);
      #1;
      case (rdy_mode)
         0:       out_ready = 1'b1;
         1:       out_ready = ~out_ready;
         default: out_ready = 1'b0;
      endcase
   end

   always @(negedge clk) begin
      for (int k = 0; k < 4; k++) begin
         if (vb[k] != 4'b0 && (k != 1 || out_ready)) begin
            if (n_str[k] < 16) dat[k][n_str[k]] = md[k];
            n_str[k]++;
            bus_or[k] |= vb[k];
         end
         if ($countones(vb[k]) > 1) viol++;
         if (pd[k]) begin
            n_done[k]++;
            ok_s[k] = po[k];
         end
      end
   end

   function automatic vec_t mk(input int nb, input logic [127:0] fr, input logic [3:0] bus,
                               input logic [3:0] dlv, input logic [3:0] care, input logic [3:0] okv,
                               input logic [2:0] e0, input logic [2:0] e1, input logic [2:0] e2,
                               input logic [2:0] e3);
      vec_t r;
      r.nb = nb; r.fr = fr; r.bus = bus; r.dlv = dlv; r.care = care; r.okv = okv;
      r.errv = {e3, e2, e1, e0};
      return r;
   endfunction

   task automatic check(input string nm, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s: got %0h, expected %0h", nm, got, exp);
      end
   endtask

   task automatic mon_clear();
      for (int k = 0; k < 4; k++) begin
         n_str[k] = 0;
         n_done[k] = 0;
         bus_or[k] = 4'b0;
      end
      ok_s = 4'b0;
   endtask

   task automatic send_byte(input logic [7:0] b);
      @(posedge clk);
      #1;
      rx_data = b;
      rx_valid = 1'b1;
      @(posedge clk);
      #1;
      rx_valid = 1'b0;
      @(posedge clk);
      @(posedge clk);
   endtask

   task automatic send_frame(input logic [127:0] fr, input int nb);
      for (int i = 0; i < nb; i++) send_byte(fr[8*(nb-1-i) +: 8]);
   endtask

   task automatic apply_vec(input int v);
      vec_t t;
      int   plen, exp_n, mism;
      t = vecs[v];
      mon_clear();
      send_frame(t.fr, t.nb);
      repeat (40) @(posedge clk);
      #1;
      plen = int'(t.fr[8*(t.nb-4) +: 8]);
      for (int k = 0; k < 4; k++) begin
         if (t.care[k]) begin
            check($sformatf("v%0d.i%0d.done", v, k), n_done[k], 1);
            check($sformatf("v%0d.i%0d.ok", v, k), ok_s[k], t.okv[k]);
            check($sformatf("v%0d.i%0d.err", v, k), ec[k], t.errv[k]);
            exp_n = t.dlv[k] ? plen : 0;
            check($sformatf("v%0d.i%0d.nstr", v, k), n_str[k], exp_n);
            if (exp_n > 0) begin
               check($sformatf("v%0d.i%0d.bus", v, k), bus_or[k], t.bus);
               mism = 0;
               for (int j = 0; j < exp_n; j++)
                  if (dat[k][j] !== t.fr[8*(t.nb-5-j) +: 8]) mism++;
               check($sformatf("v%0d.i%0d.data", v, k), mism, 0);
            end
         end
      end
   endtask

   initial begin
      int mism;
      vecs[0]  = mk(11, 128'({8'hDD, 8'h01, 8'h00, 8'h06, 8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h15}),
                    4'b0001, 4'b1111, 4'b0111, 4'b0011, 3'd0, 3'd0, 3'd1, 3'd0);
      vecs[1]  = mk(11, 128'({8'hDD, 8'h01, 8'h00, 8'h06, 8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h16}),
                    4'b0001, 4'b1101, 4'b0111, 4'b0000, 3'd1, 3'd1, 3'd1, 3'd0);
      vecs[2]  = mk(11, 128'({8'hDD, 8'h01, 8'h02, 8'h06, 8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h15}),
                    4'b0100, 4'b1111, 4'b0111, 4'b0011, 3'd0, 3'd0, 3'd1, 3'd0);
      vecs[3]  = mk(7, 128'({8'hDD, 8'h01, 8'h05, 8'h02, 8'hAA, 8'hBB, 8'h65}),
                    4'b0000, 4'b0000, 4'b1111, 4'b0000, 3'd2, 3'd2, 3'd2, 3'd2);
      vecs[4]  = mk(6, 128'({8'hDD, 8'h02, 8'h00, 8'h01, 8'h7F, 8'h7F}),
                    4'b0000, 4'b0000, 4'b1111, 4'b0000, 3'd0, 3'd0, 3'd0, 3'd0);
      vecs[5]  = mk(14, 128'({8'hDD, 8'h01, 8'h01, 8'h09, 8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06,
                              8'h07, 8'h08, 8'h09, 8'h2D}),
                    4'b0010, 4'b1101, 4'b0111, 4'b0001, 3'd0, 3'd3, 3'd1, 3'd0);
      vecs[6]  = mk(7, 128'({8'hDD, 8'h01, 8'h00, 8'h02, 8'h0F, 8'hF0, 8'hFF}),
                    4'b0001, 4'b1111, 4'b0111, 4'b0111, 3'd0, 3'd0, 3'd0, 3'd0);
      vecs[7]  = mk(5, 128'({8'hDD, 8'h01, 8'h00, 8'h00, 8'h00}),
                    4'b0000, 4'b1111, 4'b1111, 4'b1111, 3'd0, 3'd0, 3'd0, 3'd0);
      vecs[8]  = mk(7, 128'({8'hDD, 8'h01, 8'h03, 8'h02, 8'h01, 8'h02, 8'h1B}),
                    4'b1000, 4'b1101, 4'b1111, 4'b1000, 3'd1, 3'd1, 3'd1, 3'd0);
      vecs[9]  = mk(15, 128'({8'hDD, 8'h01, 8'h07, 8'h0A, 8'h10, 8'h11, 8'h12, 8'h13, 8'h14, 8'h15,
                              8'h16, 8'h17, 8'h18, 8'h19, 8'h00}),
                    4'b0000, 4'b0000, 4'b1111, 4'b0000, 3'd2, 3'd2, 3'd2, 3'd2);
      vecs[10] = mk(7, 128'({8'hDD, 8'h01, 8'h01, 8'h02, 8'hDD, 8'h01, 8'hDE}),
                    4'b0010, 4'b1111, 4'b0111, 4'b0011, 3'd0, 3'd0, 3'd1, 3'd0);

      mon_clear();
      n_rst = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      for (int k = 0; k < 4; k++)
         check($sformatf("rst.i%0d", k), {md[k], vb[k], pd[k], po[k], ec[k]}, 0);
      n_rst = 1'b1;
      rdy_mode = 1;

      for (int v = 0; v < 11; v++) apply_vec(v);

      // inter-byte timeout mid-DATA, then recovery
      mon_clear();
      send_frame(128'({8'hDD, 8'h01, 8'h00, 8'h06, 8'h01, 8'h02}), 6);
      repeat (80) @(posedge clk);
      #1;
      for (int k = 0; k < 2; k++) begin
         check($sformatf("to.i%0d.done", k), n_done[k], 1);
         check($sformatf("to.i%0d.ok", k), ok_s[k], 0);
         check($sformatf("to.i%0d.err", k), ec[k], 4);
      end
      check("to.ct_nstr", n_str[0], 2);
      check("to.sf_nstr", n_str[1], 0);
      apply_vec(0);

      // byte arriving during a stalled drain
      rdy_mode = 2;
      mon_clear();
      send_frame(vecs[2].fr, vecs[2].nb);
      repeat (10) @(posedge clk);
      #1;
      check("ovr.hold_bus", vb[1], 4'b0100);
      check("ovr.hold_data", md[1], 8'h01);
      check("ovr.nstr0", n_str[1], 0);
      send_byte(8'h55);
      repeat (3) @(posedge clk);
      #1;
      check("ovr.err", ec[1], 5);
      check("ovr.still_bus", vb[1], 4'b0100);
      rdy_mode = 0;
      repeat (20) @(posedge clk);
      #1;
      check("ovr.nstr", n_str[1], 6);
      mism = 0;
      for (int j = 0; j < 6; j++) if (dat[1][j] !== 8'(j + 1)) mism++;
      check("ovr.data", mism, 0);
      check("ovr.done", n_done[1], 1);
      check("ovr.bus_idle", vb[1], 4'b0000);
      rdy_mode = 1;
      apply_vec(7);

      // asynchronous reset while sf drains and ct is mid-DATA
      rdy_mode = 2;
      mon_clear();
      send_frame(vecs[0].fr, vecs[0].nb);
      send_frame(128'({8'hDD, 8'h01, 8'h00, 8'h06, 8'h01, 8'h02, 8'h03}), 7);
      @(negedge clk);
      check("rmid.sf_bus", vb[1], 4'b0001);
      check("rmid.ct_data", md[0], 8'h03);
      #2;
      n_rst = 1'b0;
      #1;
      for (int k = 0; k < 4; k++)
         check($sformatf("rmid.i%0d", k), {md[k], vb[k], pd[k], po[k], ec[k]}, 0);
      @(posedge clk);
      #1;
      n_rst = 1'b1;
      rdy_mode = 1;
      apply_vec(0);

      check("onehot", viol, 0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
